four_byte_sender_tx: RTL



---
 rtl/four_byte_uart_pkg.sv | 25 ++
 rtl/uart_byte_tx.sv | 99 +++++++++
 rtl/four_byte_sender_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/four_byte_uart_pkg.sv
// Shared encodings and constants for the four-byte UART transmitter.
package four_byte_uart_pkg;

  localparam int   BYTES_PER_WORD = 4;
  localparam int   BITS_PER_FRAME = 10;
  localparam logic LINE_IDLE      = 1'b1;

  typedef enum logic [1:0] {
    s_IDLE,
    s_SEND,
    s_DONE
  } word_state_e;

  typedef enum logic [1:0] {
    s_BIT_IDLE,
    s_START,
    s_DATA,
    s_STOP
  } bit_state_e;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A start request in the final stop-bit cycle chains
// the next byte with no idle gap.
module uart_byte_tx
  import four_byte_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic [7:0] i_Byte,
  output logic       o_Serial,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT = 3'(BITS_PER_FRAME - 3);

  bit_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          serial_q, serial_d;
  logic          bit_end;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= s_BIT_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      serial_q <= LINE_IDLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      serial_q <= serial_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    serial_d = LINE_IDLE;
    bit_end  = (cnt_q == LAST_CLK);
    o_Done   = (state_q == s_STOP) && bit_end;

    if (state_q != s_BIT_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      s_BIT_IDLE: begin
        if (i_Start) begin
          state_d = s_START;
          cnt_d   = '0;
          byte_d  = i_Byte;
        end
      end
      s_START: begin
        if (bit_end) begin
          state_d = s_DATA;
          bit_d   = '0;
        end
      end
      s_DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_BIT) state_d = s_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      s_STOP: begin
        if (bit_end) begin
          if (i_Start) begin
            state_d = s_START;
            byte_d  = i_Byte;
          end else begin
            state_d = s_BIT_IDLE;
          end
        end
      end
      default: state_d = s_BIT_IDLE;
    endcase

    // Line level is registered from the next state so the pin never glitches.
    case (state_d)
      s_START: serial_d = 1'b0;
      s_DATA:  serial_d = byte_d[bit_d];
      default: serial_d = LINE_IDLE;
    endcase
  end

  assign o_Serial = serial_q;
  assign o_Busy   = (state_q != s_BIT_IDLE);

endmodule

// File: rtl/four_byte_sender_tx.sv
// Sends a 32-bit word as four back-to-back 8N1 bytes, little endian.
// Optional one-word holding register: define FOUR_BYTE_TX_HOLD_EN.
module four_byte_sender_tx
  import four_byte_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Tx_DV,
  input  logic [31:0] i_Tx_Four_Bytes,
  output logic        o_Ready,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Active,
  output logic        o_Tx_Done
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  word_state_e state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  idx_q, idx_d;
  logic        accept;
  logic        eng_start, eng_busy, eng_done;
  logic [7:0]  eng_byte;
`ifdef FOUR_BYTE_TX_HOLD_EN
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_data_q, hold_data_d;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= s_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

`ifdef FOUR_BYTE_TX_HOLD_EN
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    eng_start = 1'b0;
    eng_byte  = word_byte(data_q, idx_q);
    o_Tx_Done = 1'b0;
`ifdef FOUR_BYTE_TX_HOLD_EN
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    o_Ready      = !hold_valid_q;
`else
    o_Ready      = (state_q != s_SEND);
`endif
    accept = i_Tx_DV && o_Ready;

    case (state_q)
      s_IDLE: begin
        if (accept) begin
          // Byte0 goes straight from the input so its start bit follows the accept edge.
          data_d    = i_Tx_Four_Bytes;
          idx_d     = '0;
          eng_start = 1'b1;
          eng_byte  = i_Tx_Four_Bytes[7:0];
          state_d   = s_SEND;
        end
      end
      s_SEND: begin
`ifdef FOUR_BYTE_TX_HOLD_EN
        if (accept) begin
          hold_valid_d = 1'b1;
          hold_data_d  = i_Tx_Four_Bytes;
        end
`endif
        if (eng_done) begin
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + 1'b1;
            eng_start = 1'b1;
            eng_byte  = word_byte(data_q, idx_d);
          end else begin
            state_d = s_DONE;
`ifdef FOUR_BYTE_TX_HOLD_EN
            if (hold_valid_q) begin
              data_d       = hold_data_q;
              idx_d        = '0;
              eng_start    = 1'b1;
              eng_byte     = hold_data_q[7:0];
              hold_valid_d = 1'b0;
            end
`endif
          end
        end
      end
      s_DONE: begin
        o_Tx_Done = 1'b1;
`ifdef FOUR_BYTE_TX_HOLD_EN
        if (eng_busy) begin
          // Held word already launched at the previous edge.
          state_d = s_SEND;
          if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = i_Tx_Four_Bytes;
          end
        end else if (accept) begin
`else
        if (accept) begin
`endif
          data_d    = i_Tx_Four_Bytes;
          idx_d     = '0;
          eng_start = 1'b1;
          eng_byte  = i_Tx_Four_Bytes[7:0];
          state_d   = s_SEND;
        end else begin
          state_d = s_IDLE;
        end
      end
      default: state_d = s_IDLE;
    endcase
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Start (eng_start),
    .i_Byte  (eng_byte),
    .o_Serial(o_Tx_Serial),
    .o_Busy  (eng_busy),
    .o_Done  (eng_done)
  );

  assign o_Tx_Active = eng_busy;

endmodule
